// File: rtl/clkspec_ncr_mul_sched_if.sv
// Handshake and lane bus of the round-robin multiplier scheduler: operand input,
// product output and the two external multiplier lanes.
interface clkspec_ncr_mul_sched_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   dout;
  logic                 l0_go;
  logic                 l1_go;
  logic [WIDTH-1:0]     l0_a;
  logic [WIDTH-1:0]     l0_b;
  logic [WIDTH-1:0]     l1_a;
  logic [WIDTH-1:0]     l1_b;
  logic [2*WIDTH-1:0]   l0_p;
  logic [2*WIDTH-1:0]   l1_p;
  logic                 issue_lane;
  logic                 busy;

  modport slave (
    input  in_valid, a, b, out_ready, l0_p, l1_p,
    output in_ready, out_valid, dout, l0_go, l1_go, l0_a, l0_b, l1_a, l1_b,
    output issue_lane, busy
  );

  modport master (
    output in_valid, a, b, out_ready, l0_p, l1_p,
    input  in_ready, out_valid, dout, l0_go, l1_go, l0_a, l0_b, l1_a, l1_b,
    input  issue_lane, busy
  );
endinterface

// File: rtl/clkspec_ncr_mul_sched.sv
// Two-lane round-robin multiplier scheduler: issues operand pairs to external
// fixed-latency lanes and returns products in accept order through a credited FIFO.
module clkspec_ncr_mul_sched #(
  parameter int WIDTH  = 8,
  parameter int LAT    = 2,
  parameter int FDEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  clkspec_ncr_mul_sched_if.slave bus
);
  localparam int PW    = $clog2(FDEPTH);
  localparam int CW    = PW + 1;
  localparam int PRODW = 2 * WIDTH;
  localparam logic [CW:0] CREDITS = (CW+1)'(FDEPTH);

  logic                 issue_lane;
  logic [CW-1:0]        inflight;
  logic [CW-1:0]        fifo_count;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PRODW-1:0]     fifo_mem [FDEPTH];
  logic                 vld_p0;
  logic [1:0]           go_p1;
  logic [WIDTH-1:0]     opa_p1 [2];
  logic [WIDTH-1:0]     opb_p1 [2];
  logic [LAT-1:0]       vld_p2 [2];
  logic                 vld_p3;
  logic [PRODW-1:0]     prod_p3;
  logic                 pop;

  // Stage 0: accept; credits cover every pair in flight or buffered, so the FIFO never overflows
  assign bus.in_ready = ({1'b0, inflight} + {1'b0, fifo_count}) < CREDITS;
  assign vld_p0       = bus.in_valid & bus.in_ready;

  // Stage 1: issue strobe and operand registers of the selected lane
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_lane <= 1'b0;
      go_p1      <= '0;
      for (int l = 0; l < 2; l++) begin
        opa_p1[l] <= '0;
        opb_p1[l] <= '0;
      end
    end else begin
      go_p1 <= '0;
      if (vld_p0) begin
        go_p1[issue_lane]  <= 1'b1;
        opa_p1[issue_lane] <= bus.a;
        opb_p1[issue_lane] <= bus.b;
        issue_lane         <= ~issue_lane;
      end
    end
  end

  assign bus.issue_lane = issue_lane;
  assign bus.l0_go      = go_p1[0];
  assign bus.l1_go      = go_p1[1];
  assign bus.l0_a       = opa_p1[0];
  assign bus.l0_b       = opb_p1[0];
  assign bus.l1_a       = opa_p1[1];
  assign bus.l1_b       = opb_p1[1];

  // Stage 2: per-lane valid shift registers; the tail marks the cycle the lane result is due
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < 2; l++) vld_p2[l] <= '0;
    end else begin
      for (int l = 0; l < 2; l++) vld_p2[l] <= (vld_p2[l] << 1) | LAT'(go_p1[l]);
    end
  end

  // Stage 3: sample the due lane; issues are one per cycle, so at most one tail is set
  assign vld_p3  = vld_p2[0][LAT-1] | vld_p2[1][LAT-1];
  assign prod_p3 = vld_p2[0][LAT-1] ? bus.l0_p : bus.l1_p;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else begin
      case ({vld_p0, vld_p3})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Stage 4: output FIFO
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_valid = fifo_count != '0;
  assign bus.dout      = bus.out_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.busy      = (inflight != '0) || (fifo_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (vld_p3) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({vld_p3, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p3) fifo_mem[wr_ptr] <= prod_p3;
  end
endmodule

// File: tb/tb_clkspec_ncr_mul_sched.sv
// Bench for the round-robin multiplier scheduler: models both lanes as LAT-cycle
// multipliers and checks ordering, latency, credits and reset against a queue model.
module tb_clkspec_ncr_mul_sched;
  localparam int WIDTH  = 8;
  localparam int LAT    = 2;
  localparam int FDEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  clkspec_ncr_mul_sched_if #(.WIDTH(WIDTH)) bus ();

  clkspec_ncr_mul_sched #(.WIDTH(WIDTH), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Lane models: product appears LAT cycles after go; garbage otherwise
  logic [15:0] l0_pipe [LAT];
  logic [15:0] l1_pipe [LAT];
  always @(posedge clk) begin
    l0_pipe[0] <= bus.l0_go ? 16'(bus.l0_a) * 16'(bus.l0_b) : 16'($urandom);
    l1_pipe[0] <= bus.l1_go ? 16'(bus.l1_a) * 16'(bus.l1_b) : 16'($urandom);
    for (int i = 1; i < LAT; i++) begin
      l0_pipe[i] <= l0_pipe[i-1];
      l1_pipe[i] <= l1_pipe[i-1];
    end
  end
  assign bus.l0_p = l0_pipe[LAT-1];
  assign bus.l1_p = l1_pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_during: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.dout !== 16'd0) begin n_fail++; $display("FAIL rst_dout_during: got %0d want 0", bus.dout); end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.issue_lane !== 1'b0) begin n_fail++; $display("FAIL rst_issue_lane: got %b want 0", bus.issue_lane); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.l0_go, bus.l1_go} !== 2'b00) begin n_fail++; $display("FAIL rst_go: got %b want 00", {bus.l0_go, bus.l1_go}); end
  endtask

  task automatic test_single();
    reset_dut();
    bus.in_valid = 1'b1; bus.a = 8'd3; bus.b = 8'd5;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++; if ({bus.l0_go, bus.l1_go} !== 2'b10) begin n_fail++; $display("FAIL single_go: got %b want 10", {bus.l0_go, bus.l1_go}); end
    n_cmp++; if (bus.l0_a !== 8'd3 || bus.l0_b !== 8'd5) begin n_fail++; $display("FAIL single_ops: got %0d,%0d want 3,5", bus.l0_a, bus.l0_b); end
    n_cmp++; if (bus.issue_lane !== 1'b1) begin n_fail++; $display("FAIL single_issue_lane: got %b want 1", bus.issue_lane); end
    tick();
    n_cmp++; if (bus.l0_go !== 1'b0) begin n_fail++; $display("FAIL single_go_strobe: got %b want 0", bus.l0_go); end
    n_cmp++; if (bus.l0_a !== 8'd3) begin n_fail++; $display("FAIL single_ops_hold: got %0d want 3", bus.l0_a); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", bus.out_valid); end
    tick();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.dout !== 16'd15) begin n_fail++; $display("FAIL single_out: got v=%b d=%0d want v=1 d=15", bus.out_valid, bus.dout); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_drain: got v=%b busy=%b want 0,0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  av [4] = '{8'd2, 8'd4, 8'd6, 8'd255};
    logic [7:0]  bv [4] = '{8'd3, 8'd5, 8'd7, 8'd255};
    logic [15:0] pv [4] = '{16'd6, 16'd20, 16'd42, 16'd65025};
    reset_dut();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin
        bus.in_valid = 1'b1; bus.a = av[c]; bus.b = bv[c];
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c%0d: got %b want 1", c, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if ((c - 1) % 2 == 0) begin
          if ({bus.l0_go, bus.l1_go} !== 2'b10 || bus.l0_a !== av[c-1] || bus.l0_b !== bv[c-1]) begin
            n_fail++; $display("FAIL b2b_lane0 c%0d: got go=%b%b a=%0d b=%0d want go=10 a=%0d b=%0d", c, bus.l0_go, bus.l1_go, bus.l0_a, bus.l0_b, av[c-1], bv[c-1]);
          end
        end else begin
          if ({bus.l0_go, bus.l1_go} !== 2'b01 || bus.l1_a !== av[c-1] || bus.l1_b !== bv[c-1]) begin
            n_fail++; $display("FAIL b2b_lane1 c%0d: got go=%b%b a=%0d b=%0d want go=01 a=%0d b=%0d", c, bus.l0_go, bus.l1_go, bus.l1_a, bus.l1_b, av[c-1], bv[c-1]);
          end
        end
      end
      n_cmp++;
      if (c >= 4 && c <= 7) begin
        if (bus.out_valid !== 1'b1 || bus.dout !== pv[c-4]) begin n_fail++; $display("FAIL b2b_out c%0d: got v=%b d=%0d want v=1 d=%0d", c, bus.out_valid, bus.dout, pv[c-4]); end
      end else begin
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle c%0d: got v=%b want 0", c, bus.out_valid); end
      end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_q [$];
    int acc = 0;
    reset_dut();
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back(16'(bus.a) * 16'(bus.b));
        acc++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (acc != FDEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d want %0d", acc, FDEPTH); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.dout !== exp_q[i]) begin n_fail++; $display("FAIL bp_pop%0d: got v=%b d=%0d want v=1 d=%0d", i, bus.out_valid, bus.dout, exp_q[i]); end
      if (i == 0) begin
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_same: got %b want 0", bus.in_ready); end
      end
      if (i == 1) begin
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_next: got %b want 1", bus.in_ready); end
      end
      tick();
    end
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got v=%b busy=%b want 0,0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_reset_midflight();
    reset_dut();
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = (c < 3);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_out_valid: got %b want 1", bus.out_valid); end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_async_clear: got v=%b busy=%b want 0,0", bus.out_valid, bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b want 1", bus.in_ready); end
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.issue_lane !== 1'b0) begin n_fail++; $display("FAIL mid_stale c%0d: got v=%b busy=%b lane=%b want 0,0,0", c, bus.out_valid, bus.busy, bus.issue_lane); end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] exp_q [$];
    int acc = 0;
    int popped = 0;
    int cyc = 0;
    reset_dut();
    while ((acc < 1000 || popped < 1000) && cyc < 20000) begin
      bus.in_valid  = (acc < 1000) && ($urandom_range(3) != 0);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.out_ready = ($urandom_range(2) != 0);
      n_cmp++; if (bus.in_ready !== ((acc - popped) < FDEPTH)) begin n_fail++; $display("FAIL rnd_credit c%0d: got %b outstanding=%0d", cyc, bus.in_ready, acc - popped); end
      n_cmp++; if (bus.busy !== (acc != popped)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, bus.busy, acc != popped); end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra c%0d: got d=%0d want no output", cyc, bus.dout);
        end else begin
          if (bus.dout !== exp_q[0]) begin n_fail++; $display("FAIL rnd_data #%0d: got %0d want %0d", popped, bus.dout, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        popped++;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        exp_q.push_back(16'(bus.a) * 16'(bus.b));
        acc++;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (popped != 1000 || exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_complete: got popped=%0d left=%0d want 1000,0", popped, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
